div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter: ITERS, default 32, number of radix-2 iteration cycles per division.
REQ-002 SHALL have parameter: FUSE_EN, default 1, enables the DIV/REM result-reuse path.
REQ-003 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  1  issue stage presents a divide operation.
REQ-006 SHALL have port: req_ready  output  1  sequencer accepts the request this cycle.
REQ-007 SHALL have port: req_op  input  alu_op_t  ALU_DIV, ALU_DIVU, ALU_REM or ALU_REMU.
REQ-008 SHALL have port: req_a  input  32  dividend.
REQ-009 SHALL have port: req_b  input  32  divisor.
REQ-010 SHALL have port: req_rd  input  5  destination register tag.
REQ-011 SHALL have port: flush  input  1  kill any in-flight operation.
REQ-012 SHALL have port: resp_valid  output  1  result available.
REQ-013 SHALL have port: resp_ready  input  1  writeback consumes the result.
REQ-014 SHALL have port: resp_data  output  32  quotient or remainder.
REQ-015 SHALL have port: resp_rd  output  5  tag of the returned result.
REQ-016 SHALL have port: busy  output  1  high in any state other than IDLE; drives the pipeline stall.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN, FIX, HOLD.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-019 SHALL latch op, operands, rd and operand signs on acceptance.
REQ-020 SHALL, when the accepted divisor is 0, skip RUN and go IDLE->HOLD with quotient 0xFFFFFFFF and remainder equal to the dividend; resp_valid is asserted the next cycle.
REQ-021 SHALL, for signed overflow (ALU_DIV/ALU_REM, dividend 0x80000000, divisor 0xFFFFFFFF), go IDLE->HOLD with quotient 0x80000000 and remainder 0.
REQ-022 SHALL, otherwise, convert signed operands to magnitudes (two's complement) and pulse start to div_core, going IDLE->RUN.
REQ-023 SHALL count RUN cycles with a counter that saturates at ITERS-1, then go RUN->FIX.
REQ-024 SHALL apply signs in FIX: quotient negated when the operand signs differ; remainder takes the dividend's sign; unsigned ops pass through unchanged. The state then goes FIX->HOLD.
REQ-025 SHALL hold resp_valid, resp_data and resp_rd stable in HOLD until resp_ready is high; HOLD->IDLE on that handshake.
REQ-026 SHALL produce resp_valid ITERS+2 cycles after acceptance for a normal division, and 1 cycle after acceptance for the special cases.
REQ-027 SHALL, with FUSE_EN=1, retain the last quotient and remainder together with their operands and signedness.
REQ-028 SHALL, on a new request with the same operands and signedness but the complementary op (DIV<->REM, DIVU<->REMU), go IDLE->HOLD directly with the stored result, at 1-cycle latency.
REQ-029 SHALL invalidate the reuse entry on flush and on rst.
REQ-030 SHALL return to IDLE on flush in any state the next cycle, deassert resp_valid and discard the result; flush has priority over a simultaneous resp_ready or acceptance.
REQ-031 SHALL select resp_data by op: the quotient for DIV/DIVU, the remainder for REM/REMU.

Reset
REQ-032 SHALL, on rst, set the state to IDLE and clear the counter, resp_valid, busy, resp_data, resp_rd and the reuse-valid bit; req_ready goes high the cycle after rst deasserts.
REQ-033 SHALL, on rst mid-RUN, abandon the operation with no response emitted.

Structure
REQ-034 SHALL take alu_op_t from the shared quinta package; the div_seq_state_t enum and the constants DIV_ZERO_Q=0xFFFFFFFF and INT_MIN=0x80000000 also belong there.
REQ-035 SHALL instantiate one sub-module, div_core: an unsigned radix-2 restoring divider with start, 32-bit dividend and divisor in, and quotient and remainder out, valid after ITERS cycles.
REQ-036 SHALL keep all sign handling, special cases, reuse and handshake logic in div_sequencer.

Verification
REQ-037 SHALL cover: DIV -20/3 -> resp_data 0xFFFFFFFA (-6) at acceptance+34; the following REM -20/3 -> 0xFFFFFFFE (-2) at acceptance+1 via reuse.
REQ-038 SHALL cover: DIVU 0x80000000/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; both at 1-cycle latency.
REQ-039 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-040 SHALL cover: resp_ready held low for 5 cycles -> resp_valid, resp_data and resp_rd stable, and req_ready low throughout.
REQ-041 SHALL cover: flush at RUN cycle 10 -> IDLE the next cycle, no resp_valid; the following REM with the same operands recomputes (34 cycles).
REQ-042 SHALL cover: rst asserted mid-RUN -> all outputs at reset values, then a new DIVU 100/7 -> 14.

Source files
------------

// File: rtl/quinta_pkg.sv
// Shared quinta package: ALU operation encoding plus the divide sequencer's
// state type, special-case result constants and op-decoding helpers.
package quinta_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        HOLD
    } div_seq_state_t;

    // Quotient returned for a divide by zero (all ones).
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    // Most negative 32-bit value; signed overflow dividend and its quotient.
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic op_is_rem(input alu_op_t op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic op_is_signed(input alu_op_t op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bus between the issue stage, the divide sequencer and
// writeback.
//   req_*  : issue stage -> sequencer (op, dividend, divisor, rd tag)
//   resp_* : sequencer -> writeback (result data and rd tag)
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; the sender keeps valid and its payload stable until that
// edge, and ready may depend combinationally on state but never on valid.
interface div_sequencer_if;
    import quinta_pkg::*;

    logic        req_valid;
    logic        req_ready;
    alu_op_t     req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd
    );
endinterface

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider.
//   clk, rst            : clock, synchronous active-high reset
//   start               : load dividend/divisor (one-cycle pulse)
//   dividend, divisor   : 32-bit unsigned operands, sampled on start
//   quotient, remainder : valid ITERS cycles after the start cycle
module div_core #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = $clog2(ITERS + 1);

    logic [CW-1:0] left_q, left_d;
    logic [31:0]   quo_q, quo_d;
    logic [31:0]   rem_q, rem_d;
    logic [31:0]   dvs_q, dvs_d;
    logic [32:0]   trial;
    logic [32:0]   diff;

    always_comb begin
        left_d = left_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        // Shift the next dividend bit into the partial remainder; bit 32 of
        // the difference clear means the divisor fits.
        trial  = {rem_q, quo_q[31]};
        diff   = trial - {1'b0, dvs_q};
        if (start) begin
            left_d = CW'(ITERS);
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (left_q != '0) begin
            left_d = left_q - CW'(1);
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            left_q <= left_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/div_sequencer.sv
// Divide sequencer: accepts DIV/DIVU/REM/REMU from issue, resolves the
// divide-by-zero and signed-overflow cases directly, reuses the previous
// result for the complementary op on identical operands, otherwise runs
// div_core on magnitudes and fixes up signs before returning the result.
//   clk, rst : clock, synchronous active-high reset
//   flush    : kill any in-flight operation and the reuse entry
//   busy     : high whenever the FSM is not IDLE (pipeline stall)
//   state_o  : current FSM state, for observation
//   bus      : request/response handshake (slave side)
module div_sequencer
    import quinta_pkg::*;
#(
    parameter int ITERS   = 32,
    parameter bit FUSE_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    output logic           busy,
    output div_seq_state_t state_o,
    div_sequencer_if.slave bus
);
    localparam int            CW       = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

    div_seq_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           start_q, start_d;
    alu_op_t        op_q, op_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [4:0]     rd_q, rd_d;
    logic           neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [31:0]    resp_data_q, resp_data_d;
    logic [4:0]     resp_rd_q, resp_rd_d;
    logic           fuse_valid_q, fuse_valid_d;
    logic [31:0]    fuse_a_q, fuse_a_d, fuse_b_q, fuse_b_d;
    logic           fuse_signed_q, fuse_signed_d, fuse_is_rem_q, fuse_is_rem_d;
    logic [31:0]    fuse_quo_q, fuse_quo_d, fuse_rmd_q, fuse_rmd_d;

    logic           in_signed, in_rem, fuse_hit, ovf;
    logic [31:0]    mag_a, mag_b, core_quo, core_rem, fix_quo, fix_rem;
    logic           done, done_signed, done_is_rem;
    logic [31:0]    done_quo, done_rem, done_a, done_b;
    logic [4:0]     done_rd;

    assign bus.req_ready  = (state_q == IDLE) && !flush && !rst;
    assign bus.resp_valid = (state_q == HOLD);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign busy           = (state_q != IDLE);
    assign state_o        = state_q;

    assign in_signed = op_is_signed(bus.req_op);
    assign in_rem    = op_is_rem(bus.req_op);
    assign ovf       = in_signed && (bus.req_a == INT_MIN) && (bus.req_b == 32'hFFFF_FFFF);
    // Reuse only pairs DIV with REM (or DIVU with REMU) on the very same operands.
    assign fuse_hit  = FUSE_EN && fuse_valid_q && (bus.req_a == fuse_a_q) &&
                       (bus.req_b == fuse_b_q) && (in_signed == fuse_signed_q) &&
                       (in_rem != fuse_is_rem_q);

    assign mag_a   = neg_a_q ? -a_q : a_q;
    assign mag_b   = neg_b_q ? -b_q : b_q;
    assign fix_quo = (neg_a_q ^ neg_b_q) ? -core_quo : core_quo;
    assign fix_rem = neg_a_q ? -core_rem : core_rem;

    div_core #(.ITERS(ITERS)) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (start_q),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        start_d       = 1'b0;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        rd_d          = rd_q;
        neg_a_d       = neg_a_q;
        neg_b_d       = neg_b_q;
        resp_data_d   = resp_data_q;
        resp_rd_d     = resp_rd_q;
        fuse_valid_d  = fuse_valid_q;
        fuse_a_d      = fuse_a_q;
        fuse_b_d      = fuse_b_q;
        fuse_signed_d = fuse_signed_q;
        fuse_is_rem_d = fuse_is_rem_q;
        fuse_quo_d    = fuse_quo_q;
        fuse_rmd_d    = fuse_rmd_q;
        // "done" marks the cycle a result is committed into the response
        // registers and the reuse entry; sources default to the FIX path.
        done          = 1'b0;
        done_quo      = fix_quo;
        done_rem      = fix_rem;
        done_a        = a_q;
        done_b        = b_q;
        done_rd       = rd_q;
        done_signed   = op_is_signed(op_q);
        done_is_rem   = op_is_rem(op_q);

        if (flush) begin
            state_d      = IDLE;
            fuse_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        op_d        = bus.req_op;
                        a_d         = bus.req_a;
                        b_d         = bus.req_b;
                        rd_d        = bus.req_rd;
                        neg_a_d     = in_signed & bus.req_a[31];
                        neg_b_d     = in_signed & bus.req_b[31];
                        cnt_d       = '0;
                        done_a      = bus.req_a;
                        done_b      = bus.req_b;
                        done_rd     = bus.req_rd;
                        done_signed = in_signed;
                        done_is_rem = in_rem;
                        if (fuse_hit) begin
                            done     = 1'b1;
                            done_quo = fuse_quo_q;
                            done_rem = fuse_rmd_q;
                            state_d  = HOLD;
                        end else if (bus.req_b == '0) begin
                            done     = 1'b1;
                            done_quo = DIV_ZERO_Q;
                            done_rem = bus.req_a;
                            state_d  = HOLD;
                        end else if (ovf) begin
                            done     = 1'b1;
                            done_quo = INT_MIN;
                            done_rem = '0;
                            state_d  = HOLD;
                        end else begin
                            start_d = 1'b1;
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // The start cycle only loads the core; iterations are
                    // counted from the cycle after it.
                    if (!start_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = FIX;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                FIX: begin
                    done    = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (bus.resp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (done) begin
            resp_data_d = done_is_rem ? done_rem : done_quo;
            resp_rd_d   = done_rd;
            if (FUSE_EN) begin
                fuse_valid_d  = 1'b1;
                fuse_a_d      = done_a;
                fuse_b_d      = done_b;
                fuse_signed_d = done_signed;
                fuse_is_rem_d = done_is_rem;
                fuse_quo_d    = done_quo;
                fuse_rmd_d    = done_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            start_q       <= 1'b0;
            op_q          <= ALU_DIV;
            a_q           <= '0;
            b_q           <= '0;
            rd_q          <= '0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            resp_data_q   <= '0;
            resp_rd_q     <= '0;
            fuse_valid_q  <= 1'b0;
            fuse_a_q      <= '0;
            fuse_b_q      <= '0;
            fuse_signed_q <= 1'b0;
            fuse_is_rem_q <= 1'b0;
            fuse_quo_q    <= '0;
            fuse_rmd_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rd_q          <= rd_d;
            neg_a_q       <= neg_a_d;
            neg_b_q       <= neg_b_d;
            resp_data_q   <= resp_data_d;
            resp_rd_q     <= resp_rd_d;
            fuse_valid_q  <= fuse_valid_d;
            fuse_a_q      <= fuse_a_d;
            fuse_b_q      <= fuse_b_d;
            fuse_signed_q <= fuse_signed_d;
            fuse_is_rem_q <= fuse_is_rem_d;
            fuse_quo_q    <= fuse_quo_d;
            fuse_rmd_q    <= fuse_rmd_d;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: special cases, reuse, response hold,
// flush and reset during a running division.
module tb_div_sequencer;
    import quinta_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           busy;
    div_seq_state_t state;

    div_sequencer_if bus();

    div_sequencer #(.ITERS(32), .FUSE_EN(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .busy    (busy),
        .state_o (state),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure latency from the acceptance edge, check the
    // response, optionally stall writeback for 'hold' cycles, then consume.
    task automatic do_op(input string tag, input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_data, input int exp_lat, input int hold);
        int          lat;
        logic [31:0] exp;
        exp_q.push_back(exp_data);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rd    = rd;
        bus.req_valid = 1'b1;
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.resp_valid) begin
                lat = i;
                break;
            end
        end
        exp = exp_q.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (lat == 0) return;
        check({tag, " data"}, bus.resp_data, exp);
        check({tag, " rd"}, 32'(bus.resp_rd), 32'(rd));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " req_ready low"}, 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, " hold data"}, bus.resp_data, exp);
            check({tag, " hold rd"}, 32'(bus.resp_rd), 32'(rd));
            check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check({tag, " valid after consume"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " idle after consume"}, 32'(bus.req_ready), 32'd1);
        check({tag, " busy after consume"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"}, 32'(state), 32'(IDLE));
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " resp_data"}, bus.resp_data, 32'd0);
        check({tag, " resp_rd"}, 32'(bus.resp_rd), 32'd0);
        check({tag, " req_ready in rst"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic watch_no_resp(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.resp_valid) seen = 1'b1;
        end
        check({tag, " no resp_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = ALU_DIV;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_rd     = '0;
        bus.resp_ready = 1'b0;

        // Clock/reset
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("reset release req_ready", 32'(bus.req_ready), 32'd1);

        // Signed division and reuse of its remainder
        do_op("div -20/3", ALU_DIV, 32'hFFFF_FFEC, 32'd3, 5'd1, 32'hFFFF_FFFA, 34, 0);
        do_op("rem -20/3 fuse", ALU_REM, 32'hFFFF_FFEC, 32'd3, 5'd2, 32'hFFFF_FFFE, 1, 0);

        // Divide by zero and signed overflow
        do_op("divu x/0", ALU_DIVU, 32'h8000_0000, 32'd0, 5'd3, 32'hFFFF_FFFF, 1, 0);
        do_op("remu 7/0", ALU_REMU, 32'd7, 32'd0, 5'd4, 32'd7, 1, 0);
        do_op("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 1, 0);
        do_op("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, 1, 0);
        do_op("div -5/0", ALU_DIV, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 0);
        do_op("rem -5/0", ALU_REM, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFB, 1, 0);

        // Sign combinations
        do_op("div 7/-2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 34, 0);
        do_op("rem 7/-2 fuse", ALU_REM, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, 1, 0);
        do_op("rem -20/-3", ALU_REM, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFFE, 34, 0);

        // Writeback stall, reuse, and no reuse across signedness
        do_op("divu 100/7 hold", ALU_DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 34, 5);
        do_op("remu 100/7 fuse", ALU_REMU, 32'd100, 32'd7, 5'd11, 32'd2, 1, 0);
        do_op("rem 100/7 signed", ALU_REM, 32'd100, 32'd7, 5'd20, 32'd2, 34, 0);

        // Flush at RUN cycle 10 kills the op and the reuse entry
        do_op("divu 1000/7", ALU_DIVU, 32'd1000, 32'd7, 5'd14, 32'd142, 34, 0);
        bus.req_op    = ALU_DIVU;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd7;
        bus.req_rd    = 5'd15;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (10) tick();
        check("flush pre state", 32'(state), 32'(RUN));
        check("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("flush req_ready gated", 32'(bus.req_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush state", 32'(state), 32'(IDLE));
        check("flush busy", 32'(busy), 32'd0);
        check("flush resp_valid", 32'(bus.resp_valid), 32'd0);
        watch_no_resp("after flush", 40);
        do_op("remu 1000/7 recompute", ALU_REMU, 32'd1000, 32'd7, 5'd16, 32'd6, 34, 0);

        // Reset during RUN abandons the op and the reuse entry
        bus.req_op    = ALU_DIV;
        bus.req_a     = 32'hFFFF_FF9C;
        bus.req_b     = 32'd7;
        bus.req_rd    = 5'd17;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (5) tick();
        check("mid-run state", 32'(state), 32'(RUN));
        rst = 1'b1;
        tick();
        check_reset_outputs("mid-run reset");
        rst = 1'b0;
        tick();
        check("mid-run release req_ready", 32'(bus.req_ready), 32'd1);
        watch_no_resp("after reset", 40);
        do_op("divu 1000/7 no fuse", ALU_DIVU, 32'd1000, 32'd7, 5'd19, 32'd142, 34, 0);
        do_op("divu 100/7 after rst", ALU_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, 34, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
